// File: rtl/udp_frame_wr_ctrl.sv
// udp_frame_wr_ctrl: splits 32-bit UDP payload words into 16-bit SDRAM FIFO writes with frame sync/done/error strobes.
// Define FRAME_STAT_EN to enable the saturating frame_cnt/err_cnt statistics counters.
module udp_frame_wr_ctrl #(
    parameter int          H_PIXEL     = 640,
    parameter int          V_PIXEL     = 480,
    parameter logic [31:0] FRAME_MAGIC = 32'hF0F0_5A5A
) (
    input  logic        eth_rx_clk,
    input  logic        rst_n,
    input  logic        udp_rec_en,
    input  logic [31:0] udp_rec_data,
    input  logic        udp_rec_pkt_done,
    input  logic        wr_fifo_afull,
    output logic        wr_en,
    output logic [15:0] wr_data,
    output logic        wr_load,
    output logic        frame_done,
    output logic        frame_err,
    output logic [18:0] pix_cnt,
    output logic [15:0] frame_cnt,
    output logic [15:0] err_cnt
);
    localparam logic [18:0] TOTAL = 19'(H_PIXEL * V_PIXEL);

    typedef enum logic [1:0] {IDLE, RECV, DROP} state_t;

    state_t      r_state, w_state_nx;
    logic        r_pkt_first, r_lo_pend, w_lo_pend_nx;
    logic [15:0] r_lo_data, w_wr_data_nx;
    logic        w_wr_en_nx, w_wr_load_nx, w_done_nx, w_err_nx;
    logic [18:0] w_pix_nx, w_pix_inc;
    logic        w_hdr, w_word, w_last;

    assign w_hdr     = udp_rec_en & r_pkt_first & (udp_rec_data == FRAME_MAGIC);
    assign w_word    = udp_rec_en & ~w_hdr & (r_state == RECV);
    assign w_pix_inc = pix_cnt + 19'd1;
    assign w_last    = (w_pix_inc == TOTAL);

    // A new word always wins over a pending low half; an odd-sized frame ends on its high half.
    always_comb begin
        w_state_nx   = r_state;
        w_wr_en_nx   = 1'b0;
        w_wr_data_nx = wr_data;
        w_wr_load_nx = 1'b0;
        w_done_nx    = 1'b0;
        w_err_nx     = 1'b0;
        w_pix_nx     = frame_done ? 19'd0 : pix_cnt;
        w_lo_pend_nx = 1'b0;
        if (w_hdr) begin
            w_wr_load_nx = 1'b1;
            w_err_nx     = (r_state == RECV);
            w_pix_nx     = 19'd0;
            w_state_nx   = RECV;
        end else if (w_word && wr_fifo_afull) begin
            w_err_nx   = 1'b1;
            w_state_nx = DROP;
        end else if (w_word) begin
            w_wr_en_nx   = 1'b1;
            w_wr_data_nx = udp_rec_data[31:16];
            w_pix_nx     = w_pix_inc;
            w_lo_pend_nx = ~w_last;
            w_done_nx    = w_last;
            w_state_nx   = w_last ? IDLE : r_state;
        end else if (r_lo_pend) begin
            w_wr_en_nx   = 1'b1;
            w_wr_data_nx = r_lo_data;
            w_pix_nx     = w_pix_inc;
            w_done_nx    = w_last;
            w_state_nx   = w_last ? IDLE : r_state;
        end
    end

    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= IDLE;
            r_pkt_first <= 1'b1;
            r_lo_pend   <= 1'b0;
            r_lo_data   <= '0;
            wr_en       <= 1'b0;
            wr_data     <= '0;
            wr_load     <= 1'b0;
            frame_done  <= 1'b0;
            frame_err   <= 1'b0;
            pix_cnt     <= '0;
        end else begin
            r_state     <= w_state_nx;
            r_pkt_first <= udp_rec_pkt_done ? 1'b1 : (udp_rec_en ? 1'b0 : r_pkt_first);
            r_lo_pend   <= w_lo_pend_nx;
            r_lo_data   <= w_word ? udp_rec_data[15:0] : r_lo_data;
            wr_en       <= w_wr_en_nx;
            wr_data     <= w_wr_data_nx;
            wr_load     <= w_wr_load_nx;
            frame_done  <= w_done_nx;
            frame_err   <= w_err_nx;
            pix_cnt     <= w_pix_nx;
        end
    end

`ifdef FRAME_STAT_EN
    always_ff @(posedge eth_rx_clk or negedge rst_n) begin
        if (!rst_n) begin
            frame_cnt <= '0;
            err_cnt   <= '0;
        end else begin
            frame_cnt <= (frame_done && frame_cnt != 16'hFFFF) ? frame_cnt + 16'd1 : frame_cnt;
            err_cnt   <= (frame_err && err_cnt != 16'hFFFF) ? err_cnt + 16'd1 : err_cnt;
        end
    end
`else
    assign frame_cnt = '0;
    assign err_cnt   = '0;
`endif
endmodule

// File: tb/tb_udp_frame_wr_ctrl.sv
// tb_udp_frame_wr_ctrl: directed bench with an even (4x1) and an odd (3x1) frame instance sharing one stimulus.
module tb_udp_frame_wr_ctrl;
    localparam logic [31:0] MAGIC = 32'hF0F0_5A5A;

    logic        eth_rx_clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        udp_rec_en = 1'b0;
    logic [31:0] udp_rec_data = '0;
    logic        udp_rec_pkt_done = 1'b0;
    logic        wr_fifo_afull = 1'b0;

    logic        wr_en_a, wr_load_a, frame_done_a, frame_err_a;
    logic [15:0] wr_data_a, frame_cnt_a, err_cnt_a;
    logic [18:0] pix_cnt_a;
    logic        wr_en_b, wr_load_b, frame_done_b, frame_err_b;
    logic [15:0] wr_data_b, frame_cnt_b, err_cnt_b;
    logic [18:0] pix_cnt_b;

    int errors = 0;
    int checks = 0;

    udp_frame_wr_ctrl #(.H_PIXEL(4), .V_PIXEL(1), .FRAME_MAGIC(MAGIC)) dut_a (
        .eth_rx_clk(eth_rx_clk), .rst_n(rst_n), .udp_rec_en(udp_rec_en), .udp_rec_data(udp_rec_data),
        .udp_rec_pkt_done(udp_rec_pkt_done), .wr_fifo_afull(wr_fifo_afull), .wr_en(wr_en_a),
        .wr_data(wr_data_a), .wr_load(wr_load_a), .frame_done(frame_done_a), .frame_err(frame_err_a),
        .pix_cnt(pix_cnt_a), .frame_cnt(frame_cnt_a), .err_cnt(err_cnt_a));

    udp_frame_wr_ctrl #(.H_PIXEL(3), .V_PIXEL(1), .FRAME_MAGIC(MAGIC)) dut_b (
        .eth_rx_clk(eth_rx_clk), .rst_n(rst_n), .udp_rec_en(udp_rec_en), .udp_rec_data(udp_rec_data),
        .udp_rec_pkt_done(udp_rec_pkt_done), .wr_fifo_afull(wr_fifo_afull), .wr_en(wr_en_b),
        .wr_data(wr_data_b), .wr_load(wr_load_b), .frame_done(frame_done_b), .frame_err(frame_err_b),
        .pix_cnt(pix_cnt_b), .frame_cnt(frame_cnt_b), .err_cnt(err_cnt_b));

    always #5 eth_rx_clk = ~eth_rx_clk;

    // Packed view: {wr_en, wr_data, pix_cnt, wr_load, frame_done, frame_err}
    function automatic logic [63:0] pk(input logic en, input logic [15:0] d, input logic [18:0] p,
                                       input logic ld, input logic dn, input logic er);
        return {25'd0, en, d, p, ld, dn, er};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic ca(input string tag, input logic en, input logic [15:0] d, input logic [18:0] p,
                      input logic ld, input logic dn, input logic er);
        chk({"A ", tag}, pk(wr_en_a, wr_data_a, pix_cnt_a, wr_load_a, frame_done_a, frame_err_a),
            pk(en, d, p, ld, dn, er));
    endtask

    task automatic cb(input string tag, input logic en, input logic [15:0] d, input logic [18:0] p,
                      input logic ld, input logic dn, input logic er);
        chk({"B ", tag}, pk(wr_en_b, wr_data_b, pix_cnt_b, wr_load_b, frame_done_b, frame_err_b),
            pk(en, d, p, ld, dn, er));
    endtask

    task automatic cstat(input string tag, input logic [15:0] fc, input logic [15:0] ec);
        chk({"A ", tag}, {32'd0, frame_cnt_a, err_cnt_a}, {32'd0, fc, ec});
        chk({"B ", tag}, {32'd0, frame_cnt_b, err_cnt_b}, {32'd0, fc, ec});
    endtask

    task automatic step();
        @(posedge eth_rx_clk);
        #1;
    endtask

    task automatic word(input logic [31:0] d, input logic done, input logic af);
        udp_rec_en = 1'b1;
        udp_rec_data = d;
        udp_rec_pkt_done = done;
        wr_fifo_afull = af;
        step();
        udp_rec_en = 1'b0;
        udp_rec_pkt_done = 1'b0;
        wr_fifo_afull = 1'b0;
    endtask

    initial begin
        repeat (3) step();
        ca("rst", 0, 16'h0000, 0, 0, 0, 0);
        cb("rst", 0, 16'h0000, 0, 0, 0, 0);
        cstat("rst stat", 16'd0, 16'd0);
        rst_n = 1'b1;
        step();

        word(MAGIC, 0, 0);
        ca("t1 hdr", 0, 16'h0000, 0, 1, 0, 0);
        cb("t1 hdr", 0, 16'h0000, 0, 1, 0, 0);
        step();
        ca("t1 load off", 0, 16'h0000, 0, 0, 0, 0);
        step();
        word(32'h1111_2222, 1, 0);
        ca("t1 hi", 1, 16'h1111, 1, 0, 0, 0);
        cb("t1 hi", 1, 16'h1111, 1, 0, 0, 0);
        step();
        ca("t1 lo", 1, 16'h2222, 2, 0, 0, 0);
        cb("t1 lo", 1, 16'h2222, 2, 0, 0, 0);
        step();
        ca("t1 hold", 0, 16'h2222, 2, 0, 0, 0);

        word(32'h3333_4444, 0, 0);
        ca("t2 hi", 1, 16'h3333, 3, 0, 0, 0);
        cb("t2 odd done", 1, 16'h3333, 3, 0, 1, 0);
        step();
        ca("t2 done", 1, 16'h4444, 4, 0, 1, 0);
        cb("t2 odd lo dropped", 0, 16'h3333, 0, 0, 0, 0);
        step();
        ca("t2 clear", 0, 16'h4444, 0, 0, 0, 0);
        step();
        word(32'h5555_6666, 1, 0);
        ca("t2 extra ignored", 0, 16'h4444, 0, 0, 0, 0);
        cb("t2 extra ignored", 0, 16'h3333, 0, 0, 0, 0);
        step();
        ca("t2 extra ignored lo", 0, 16'h4444, 0, 0, 0, 0);
        step();

        word(MAGIC, 0, 0);
        ca("t3 hdr", 0, 16'h4444, 0, 1, 0, 0);
        cb("t3 hdr", 0, 16'h3333, 0, 1, 0, 0);
        step();
        step();
        word(32'hAAAA_BBBB, 1, 0);
        ca("t3 hi", 1, 16'hAAAA, 1, 0, 0, 0);
        step();
        ca("t3 lo", 1, 16'hBBBB, 2, 0, 0, 0);
        cb("t3 lo", 1, 16'hBBBB, 2, 0, 0, 0);
        step();
        word(MAGIC, 0, 0);
        ca("t3 short frame", 0, 16'hBBBB, 0, 1, 0, 1);
        cb("t3 short frame", 0, 16'hBBBB, 0, 1, 0, 1);
        step();
        ca("t3 strobes off", 0, 16'hBBBB, 0, 0, 0, 0);
        step();
        word(32'hCCCC_DDDD, 0, 0);
        ca("t3 restart hi", 1, 16'hCCCC, 1, 0, 0, 0);
        step();
        ca("t3 restart lo", 1, 16'hDDDD, 2, 0, 0, 0);
        step();

        word(MAGIC, 0, 0);
        ca("t5 magic as data hi", 1, 16'hF0F0, 3, 0, 0, 0);
        cb("t5 magic as data odd", 1, 16'hF0F0, 3, 0, 1, 0);
        step();
        ca("t5 magic as data lo", 1, 16'h5A5A, 4, 0, 1, 0);
        cb("t5 odd after", 0, 16'hF0F0, 0, 0, 0, 0);
        step();
        ca("t5 clear", 0, 16'h5A5A, 0, 0, 0, 0);
        step();
        word(32'h1234_5678, 1, 0);
        ca("t5 idle ignore", 0, 16'h5A5A, 0, 0, 0, 0);
        cb("t5 idle ignore", 0, 16'hF0F0, 0, 0, 0, 0);
        step();
        step();

        word(MAGIC, 0, 0);
        ca("t4 hdr", 0, 16'h5A5A, 0, 1, 0, 0);
        step();
        step();
        word(32'h1111_2222, 0, 1);
        ca("t4 afull", 0, 16'h5A5A, 0, 0, 0, 1);
        cb("t4 afull", 0, 16'hF0F0, 0, 0, 0, 1);
        step();
        ca("t4 afull lo", 0, 16'h5A5A, 0, 0, 0, 0);
        step();
        word(32'h3333_4444, 1, 0);
        ca("t4 dropped", 0, 16'h5A5A, 0, 0, 0, 0);
        step();
        ca("t4 dropped lo", 0, 16'h5A5A, 0, 0, 0, 0);
        step();
        word(MAGIC, 0, 0);
        ca("t4 resync", 0, 16'h5A5A, 0, 1, 0, 0);
        cb("t4 resync", 0, 16'hF0F0, 0, 1, 0, 0);
        step();
        step();
`ifdef FRAME_STAT_EN
        cstat("stat counts", 16'd2, 16'd2);
`endif

        word(32'h5555_6666, 0, 0);
        ca("t6 hi", 1, 16'h5555, 1, 0, 0, 0);
        rst_n = 1'b0;
        #1;
        ca("t6 async clear", 0, 16'h0000, 0, 0, 0, 0);
        cb("t6 async clear", 0, 16'h0000, 0, 0, 0, 0);
        step();
        ca("t6 no lo", 0, 16'h0000, 0, 0, 0, 0);
        cstat("t6 stat clear", 16'd0, 16'd0);
        rst_n = 1'b1;
        step();
        word(32'h7777_8888, 0, 0);
        ca("t6 first ignored", 0, 16'h0000, 0, 0, 0, 0);
        cb("t6 first ignored", 0, 16'h0000, 0, 0, 0, 0);
        step();
        ca("t6 first ignored lo", 0, 16'h0000, 0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
